// File: rtl/hd_pkg.sv
// ---------------------------------------------------------------------------
// hd_pkg
// Shared definitions for the hyperdimensional bundling datapath.
//   HV_DIM      : width of one hypervector slice (one input beat)
//   NUM_BIND    : number of bound vectors folded into one bundle
//   BUND_CW     : per-dimension counter width, large enough to hold NUM_BIND
//   BUND_THRESH : majority threshold; a dimension votes 1 when its count
//                 is >= BUND_THRESH (ties resolve to 1)
// ---------------------------------------------------------------------------
package hd_pkg;

    localparam int HV_DIM      = 64;
    localparam int NUM_BIND    = 144;
    localparam int BUND_CW     = $clog2(NUM_BIND + 1);
    localparam int BUND_THRESH = NUM_BIND / 2;

    typedef logic [HV_DIM-1:0] hv_slice_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } bundle_state_t;

endpackage

// File: rtl/bundle_ctrl_if.sv
// ---------------------------------------------------------------------------
// bundle_ctrl_if
// Stream bundle for the bundling controller: an input valid/ready beat
// channel carrying bound hypervector slices and an output valid/ready
// channel carrying the binarized bundled hypervector.
//   slave  : controller side (consumes in_*, produces out_*)
//   master : producer/consumer side around the controller
// Signals:
//   in_valid  / in_ready  / in_vec  : input beat handshake + D-bit slice
//   out_valid / out_ready / out_hv  : result handshake + D-bit result
// ---------------------------------------------------------------------------
interface bundle_ctrl_if
    import hd_pkg::*;
#(
    parameter int D = HV_DIM
);

    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] out_hv;

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_hv
    );

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_hv
    );

endinterface

// File: rtl/bundle_acc.sv
// ---------------------------------------------------------------------------
// bundle_acc
// Array of D per-dimension popcount registers for majority-vote bundling.
// Each counter adds its bit of the incoming slice when enabled. The
// majority outputs are computed from the count *including* the current
// beat, so the controller can capture the final result on the same edge
// that accepts the last beat.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset, clears all counters
//   i_clr      in   synchronous clear of all counters (priority over i_en)
//   i_en       in   add i_bits into the counters this edge
//   i_bits     in   D-bit bound slice
//   o_maj_next out  per-dimension (count + i_bits) >= THRESH
// ---------------------------------------------------------------------------
module bundle_acc
    import hd_pkg::*;
#(
    parameter int D      = HV_DIM,
    parameter int CW     = BUND_CW,
    parameter int THRESH = BUND_THRESH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [D-1:0] i_bits,
    output logic [D-1:0] o_maj_next
);

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_cnt
            logic [CW-1:0] r_cnt;
            logic [CW-1:0] w_sum;

            // CW holds the full item count, so the sum never wraps when
            // the controller enables at most NUM_ITEMS beats.
            assign w_sum = r_cnt + CW'(i_bits[gi]);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (i_clr) begin
                    r_cnt <= '0;
                end else if (i_en) begin
                    r_cnt <= w_sum;
                end
            end

            assign o_maj_next[gi] = (w_sum >= CW'(THRESH));
        end
    endgenerate

endmodule

// File: rtl/bundle_ctrl.sv
// ---------------------------------------------------------------------------
// bundle_ctrl
// Sequencing controller for majority-vote bundling of NUM_ITEMS bound
// hypervector slices. After start, the controller accepts exactly
// NUM_ITEMS beats, then presents the thresholded result until the
// downstream takes it.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   start     in   begin an operation (only honoured in IDLE)
//   abort     in   clear the current operation, return to IDLE; wins over
//                  start, beat acceptance and the output handshake
//   bus       if   slave side of bundle_ctrl_if (in_*/out_* streams)
//   busy      out  high in ACCUM or EMIT
//   done      out  combinational pulse on the output handshake
//   item_cnt  out  beats accepted in the current operation
// ---------------------------------------------------------------------------
module bundle_ctrl
    import hd_pkg::*;
#(
    parameter int D         = HV_DIM,
    parameter int NUM_ITEMS = NUM_BIND,
    parameter int THRESH    = NUM_ITEMS / 2,
    parameter int CW        = $clog2(NUM_ITEMS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    bundle_ctrl_if.slave    bus,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   item_cnt
);

    bundle_state_t r_state;
    bundle_state_t w_state_next;

    logic [CW-1:0] r_item_cnt;
    logic [D-1:0]  r_out_hv;

    logic          w_accept;
    logic          w_last;
    logic          w_acc_clr;
    logic          w_acc_en;
    logic          w_load_hv;
    logic [D-1:0]  w_maj_next;

    // in_ready is purely a function of state, so a beat is accepted
    // whenever the producer is valid while we sit in ACCUM.
    assign w_accept = (r_state == ACCUM) && bus.in_valid;
    assign w_last   = w_accept && (r_item_cnt == CW'(NUM_ITEMS - 1));

    bundle_acc #(
        .D      (D),
        .CW     (CW),
        .THRESH (THRESH)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_acc_clr),
        .i_en       (w_acc_en),
        .i_bits     (bus.in_vec),
        .o_maj_next (w_maj_next)
    );

    // ---------------- next-state / control ----------------
    always_comb begin
        w_state_next = r_state;
        w_acc_clr    = 1'b0;
        w_acc_en     = 1'b0;
        w_load_hv    = 1'b0;

        if (abort) begin
            // abort overrides everything else in the same cycle
            w_state_next = IDLE;
            w_acc_clr    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_next = ACCUM;
                        w_acc_clr    = 1'b1;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        w_acc_en = 1'b1;
                        if (w_last) begin
                            // capture majority including this final beat
                            w_state_next = EMIT;
                            w_load_hv    = 1'b1;
                        end
                    end
                end
                EMIT: begin
                    // start here is ignored; it is only seen again in IDLE
                    if (bus.out_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- item counter ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_item_cnt <= '0;
        end else if (w_acc_clr) begin
            r_item_cnt <= '0;
        end else if (w_acc_en) begin
            r_item_cnt <= r_item_cnt + CW'(1);
        end
    end

    // ---------------- result register ----------------
    // Holds its value after the handshake and across abort; only a fresh
    // completed operation or reset changes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_hv <= '0;
        end else if (w_load_hv) begin
            r_out_hv <= w_maj_next;
        end
    end

    // ---------------- outputs ----------------
    assign bus.in_ready  = (r_state == ACCUM);
    assign bus.out_valid = (r_state == EMIT);
    assign bus.out_hv    = r_out_hv;
    assign busy          = (r_state != IDLE);
    assign done          = (r_state == EMIT) && bus.out_ready && !abort;
    assign item_cnt      = r_item_cnt;

endmodule

// File: tb/tb_bundle_ctrl.sv
// Self-checking bench for bundle_ctrl: randomized beats checked against a
// per-dimension majority model computed from the list of accepted beats.
module tb_bundle_ctrl;
    import hd_pkg::*;

    localparam int N   = NUM_BIND;
    localparam int THR = BUND_THRESH;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic [BUND_CW-1:0] item_cnt;

    bundle_ctrl_if #(.D(HV_DIM)) bus ();

    bundle_ctrl #(
        .D         (HV_DIM),
        .NUM_ITEMS (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .item_cnt (item_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    hv_slice_t beats[$];
    hv_slice_t all_ones = '1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic hv_slice_t rand_hv();
        return {$urandom, $urandom};
    endfunction

    // Majority vote straight from the list of beats of one operation.
    function automatic hv_slice_t model(input hv_slice_t q[$]);
        hv_slice_t r = '0;
        for (int k = 0; k < HV_DIM; k++) begin
            int ones = 0;
            foreach (q[i]) ones += int'(q[i][k]);
            r[k] = (ones >= THR);
        end
        return r;
    endfunction

    task automatic fill_random(input int n);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back(rand_hv());
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Presents every beat in the queue, with random idle gaps; ok=0 if a
    // beat is never accepted within its cycle budget.
    task automatic feed(input int gap_pct, output bit ok);
        ok = 1'b1;
        foreach (beats[i]) begin
            int g = 0;
            int tries = 0;
            while (g < 8 && int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in_vec   = rand_hv();
                step();
                g++;
            end
            bus.in_valid = 1'b1;
            bus.in_vec   = beats[i];
            while (bus.in_ready !== 1'b1 && tries < 20) begin
                step();
                tries++;
            end
            if (tries >= 20) begin
                ok = 1'b0;
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; start = 1'b1; abort = 1'b0;
        bus.in_valid = 1'b1; bus.in_vec = rand_hv(); bus.out_ready = 1'b1;
        step(); step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (item_cnt !== '0) begin bad++; $display("FAIL reset_item_cnt: got %0d want 0", item_cnt); end
        total++; if (bus.out_hv !== '0) begin bad++; $display("FAIL reset_out_hv: got %h want 0", bus.out_hv); end
        start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; rst_n = 1'b1;
        step();
        ok = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_start();
        fill_random(50);
        feed(0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_feed_timeout: got %b want 1", ok); end
        total++; if (item_cnt !== 50) begin bad++; $display("FAIL rmid_item_cnt: got %0d want 50", item_cnt); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
        total++; if (item_cnt !== '0) begin bad++; $display("FAIL rmid_item_cnt0: got %0d want 0", item_cnt); end
        total++; if (bus.out_hv !== '0) begin bad++; $display("FAIL rmid_out_hv0: got %h want 0", bus.out_hv); end
        do_start();
        beats.delete();
        for (int i = 0; i < N; i++) beats.push_back(all_ones);
        feed(0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_feed2_timeout: got %b want 1", ok); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rmid_latency: out_valid got %b want 1", bus.out_valid); end
        total++; if (bus.out_hv !== all_ones) begin bad++; $display("FAIL rmid_ones: got %h want %h", bus.out_hv, all_ones); end
        bus.out_ready = 1'b1;
        #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rmid_done: got %b want 1", done); end
        step();
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid_drop: got %b want 0", bus.out_valid); end
        total++; if (bus.out_hv !== all_ones) begin bad++; $display("FAIL rmid_hv_retain: got %h want %h", bus.out_hv, all_ones); end
        $display("reset_mid: all-ones result %h", bus.out_hv);
    endtask

    task automatic test_tie();
        bit ok;
        hv_slice_t v;
        beats.delete();
        for (int i = 0; i < N; i++) begin
            v = '0;
            v[0] = (i < THR);
            v[1] = (i < THR - 1);
            beats.push_back(v);
        end
        do_start();
        feed(0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL tie_feed_timeout: got %b want 1", ok); end
        total++; if (bus.out_hv !== 64'h1) begin bad++; $display("FAIL tie_out_hv: got %h want %h", bus.out_hv, 64'h1); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        $display("tie: out_hv=%h", bus.out_hv);
    endtask

    task automatic test_stall();
        bit ok;
        hv_slice_t exp;
        int pulses = 0;
        fill_random(N);
        exp = model(beats);
        do_start();
        feed(30, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_feed_timeout: got %b want 1", ok); end
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'($urandom_range(1));
            bus.in_vec   = rand_hv();
            #1;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid c%0d: got %b want 1", c, bus.out_valid); end
            total++; if (bus.out_hv !== exp) begin bad++; $display("FAIL stall_out_hv c%0d: got %h want %h", c, bus.out_hv, exp); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c%0d: got %b want 0", c, bus.in_ready); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL stall_done c%0d: got %b want 0", c, done); end
            total++; if (item_cnt !== N) begin bad++; $display("FAIL stall_item_cnt c%0d: got %0d want %0d", c, item_cnt, N); end
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (done === 1'b1) pulses++;
            step();
        end
        bus.out_ready = 1'b0;
        total++; if (pulses !== 1) begin bad++; $display("FAIL stall_done_pulses: got %0d want 1", pulses); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_busy_after: got %b want 0", busy); end
        $display("stall: out_hv=%h expected=%h pulses=%0d", bus.out_hv, exp, pulses);
    endtask

    task automatic test_abort();
        bit ok;
        fill_random(N - 1);
        do_start();
        feed(20, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL abort_feed_timeout: got %b want 1", ok); end
        total++; if (item_cnt !== N - 1) begin bad++; $display("FAIL abort_pre_cnt: got %0d want %0d", item_cnt, N - 1); end
        bus.in_valid = 1'b1; bus.in_vec = rand_hv(); abort = 1'b1; bus.out_ready = 1'b1;
        step();
        abort = 1'b0; bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid: got %b want 0", bus.out_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (item_cnt !== '0) begin bad++; $display("FAIL abort_item_cnt: got %0d want 0", item_cnt); end
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid_late: got %b want 0", bus.out_valid); end
        bus.out_ready = 1'b0;
        // abort during EMIT together with out_ready: no done pulse
        fill_random(N);
        do_start();
        feed(0, ok);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL abort_emit_setup: got %b want 1", bus.out_valid); end
        abort = 1'b1; bus.out_ready = 1'b1;
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_emit_done: got %b want 0", done); end
        step();
        abort = 1'b0; bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_emit_out_valid: got %b want 0", bus.out_valid); end
        total++; if (item_cnt !== '0) begin bad++; $display("FAIL abort_emit_item_cnt: got %0d want 0", item_cnt); end
        $display("abort: last-beat and emit aborts checked");
    endtask

    task automatic test_start_ignored();
        bit ok;
        hv_slice_t exp;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1; bus.in_vec = rand_hv();
            #1;
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready c%0d: got %b want 0", c, bus.in_ready); end
            step();
        end
        bus.in_valid = 1'b0;
        total++; if (item_cnt !== '0) begin bad++; $display("FAIL idle_item_cnt: got %0d want 0", item_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
        fill_random(N);
        exp = model(beats);
        start = 1'b1;
        step();
        feed(10, ok);   // start stays high throughout ACCUM
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL sign_feed_timeout: got %b want 1", ok); end
        total++; if (item_cnt !== N) begin bad++; $display("FAIL sign_item_cnt: got %0d want %0d", item_cnt, N); end
        for (int c = 0; c < 3; c++) begin
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL sign_emit_valid c%0d: got %b want 1", c, bus.out_valid); end
            step();
        end
        start = 1'b0;
        total++; if (bus.out_hv !== exp) begin bad++; $display("FAIL sign_out_hv: got %h want %h", bus.out_hv, exp); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        $display("start_ignored: out_hv=%h expected=%h", bus.out_hv, exp);
    endtask

    task automatic test_back_to_back();
        bit ok;
        hv_slice_t exp;
        do_start();
        for (int op = 0; op < 20; op++) begin
            fill_random(N);
            exp = model(beats);
            feed(30, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_feed_timeout op%0d: got %b want 1", op, ok); end
            total++; if (bus.out_hv !== exp) begin bad++; $display("FAIL b2b_out_hv op%0d: got %h want %h", op, bus.out_hv, exp); end
            $display("op %0d: out_hv=%h expected=%h", op, bus.out_hv, exp);
            for (int d = int'($urandom_range(3)); d > 0; d--) step();
            bus.out_ready = 1'b1;
            start = 1'b1;   // same cycle as handshake: must not be honoured
            #1;
            total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done op%0d: got %b want 1", op, done); end
            step();
            bus.out_ready = 1'b0;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle op%0d: got %b want 0", op, busy); end
            if (op < 19) begin
                step();
                start = 1'b0;
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart op%0d: got %b want 1", op, busy); end
                total++; if (item_cnt !== '0) begin bad++; $display("FAIL b2b_cnt_clr op%0d: got %0d want 0", op, item_cnt); end
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_vec = '0; bus.out_ready = 1'b0;
        test_reset();
        test_reset_mid();
        test_tie();
        test_stall();
        test_abort();
        test_start_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
